// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci LFSR random source with seed reload and a
// request/valid draw port returning a uniform value below a limit.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   en              step the LFSR while idle
//   seed_load/in    load a new seed (zero maps to SEED)
//   req/limit       start a draw with exclusive upper bound (0 = full)
//   state_out       current LFSR state, bit_out = state_out[0]
//   busy            draw in progress
//   valid/value     one-cycle result pulse, value held between draws
//   fallback        result came from the retry limit
module lfsr_rng #(
   parameter int                 WIDTH     = 16,
   parameter logic [WIDTH-1:0]   TAPS      = WIDTH'(16'hB400),
   parameter logic [WIDTH-1:0]   SEED      = WIDTH'(16'h0001),
   parameter int                 OUT_BITS  = 2,
   parameter int                 MAX_TRIES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                seed_load,
   input  logic [WIDTH-1:0]    seed_in,
   input  logic                req,
   input  logic [OUT_BITS-1:0] limit,
   output logic [WIDTH-1:0]    state_out,
   output logic                bit_out,
   output logic                busy,
   output logic                valid,
   output logic [OUT_BITS-1:0] value,
   output logic                fallback
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TRY_MAX = TW'(MAX_TRIES);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_DRAW = 1'b1;

   logic [WIDTH-1:0]    state_q, state_d;
   logic [0:0]          fsm_q, fsm_d;
   logic [OUT_BITS-1:0] limit_q, limit_d;
   logic [TW-1:0]       try_q, try_d;
   logic [OUT_BITS-1:0] value_q, value_d;
   logic                fallback_q, fallback_d;
   logic                valid_q, valid_d;

   logic                fb;
   logic [WIDTH-1:0]    stepped;
   logic [OUT_BITS-1:0] cand;
   logic                accept;
   logic                do_step;
   logic [TW-1:0]       try_inc;

   always_comb begin
      fb      = ^(state_q & TAPS);
      stepped = {state_q[WIDTH-2:0], fb};
      cand    = state_q[OUT_BITS-1:0];
      accept  = (limit_q == '0) || (cand < limit_q);
      try_inc = try_q + 1'b1;
      // the draw consumes one LFSR step per candidate, independent of en
      do_step = (fsm_q == S_DRAW) ? 1'b1 : en;

      state_d    = state_q;
      fsm_d      = fsm_q;
      limit_d    = limit_q;
      try_d      = try_q;
      value_d    = value_q;
      fallback_d = fallback_q;
      valid_d    = 1'b0;

      // a zero seed would lock the LFSR, so it is replaced by SEED
      if (seed_load)
         state_d = (seed_in == '0) ? SEED : seed_in;
      else if (do_step)
         state_d = stepped;

      case (fsm_q)
         S_IDLE: begin
            if (req) begin
               fsm_d   = S_DRAW;
               limit_d = limit;
               try_d   = '0;
            end
         end
         S_DRAW: begin
            if (accept) begin
               value_d    = cand;
               fallback_d = 1'b0;
               valid_d    = 1'b1;
               fsm_d      = S_IDLE;
            end else if (try_inc == TRY_MAX) begin
               value_d    = '0;
               fallback_d = 1'b1;
               valid_d    = 1'b1;
               fsm_d      = S_IDLE;
               try_d      = try_inc;
            end else begin
               try_d = try_inc;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SEED;
         fsm_q      <= S_IDLE;
         limit_q    <= '0;
         try_q      <= '0;
         value_q    <= '0;
         fallback_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fsm_q      <= fsm_d;
         limit_q    <= limit_d;
         try_q      <= try_d;
         value_q    <= value_d;
         fallback_q <= fallback_d;
         valid_q    <= valid_d;
      end
   end

   assign state_out = state_q;
   assign bit_out   = state_q[0];
   assign busy      = (fsm_q == S_DRAW);
   assign valid     = valid_q;
   assign value     = value_q;
   assign fallback  = fallback_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: table-driven and scoreboard bench for lfsr_rng.
// Instance a uses defaults; instance b uses MAX_TRIES = 2.
module tb_lfsr_rng;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_a, seed_load_a, req_a;
   logic [15:0] seed_in_a;
   logic [1:0]  limit_a;
   logic [15:0] state_a;
   logic        bit_a, busy_a, valid_a, fb_a;
   logic [1:0]  value_a;

   logic        en_b, seed_load_b, req_b;
   logic [15:0] seed_in_b;
   logic [1:0]  limit_b;
   logic [15:0] state_b;
   logic        bit_b, busy_b, valid_b, fb_b;
   logic [1:0]  value_b;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lfsr_rng u_a (
      .clk(clk), .reset(reset), .en(en_a),
      .seed_load(seed_load_a), .seed_in(seed_in_a),
      .req(req_a), .limit(limit_a),
      .state_out(state_a), .bit_out(bit_a), .busy(busy_a),
      .valid(valid_a), .value(value_a), .fallback(fb_a)
   );

   lfsr_rng #(.MAX_TRIES(2)) u_b (
      .clk(clk), .reset(reset), .en(en_b),
      .seed_load(seed_load_b), .seed_in(seed_in_b),
      .req(req_b), .limit(limit_b),
      .state_out(state_b), .bit_out(bit_b), .busy(busy_b),
      .valid(valid_b), .value(value_b), .fallback(fb_b)
   );

   typedef struct {
      logic [15:0] seed;
      logic [1:0]  lim;
      logic [1:0]  val;
      logic        fb;
      int          edges;
   } vec_t;

   typedef struct {
      logic [1:0] val;
      logic       fb;
      int         cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid_a === 1'b1) begin
         tests++;
         if (q_a.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid_a: value=%0d", value_a);
         end else begin
            e = q_a.pop_front();
            if (value_a !== e.val || fb_a !== e.fb || cyc != e.cyc) begin
               fails++;
               $display("FAIL draw_a: got v=%0d fb=%0b cyc=%0d, want v=%0d fb=%0b cyc=%0d",
                        value_a, fb_a, cyc, e.val, e.fb, e.cyc);
            end
         end
      end
      if (valid_b === 1'b1) begin
         tests++;
         if (q_b.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid_b: value=%0d", value_b);
         end else begin
            e = q_b.pop_front();
            if (value_b !== e.val || fb_b !== e.fb || cyc != e.cyc) begin
               fails++;
               $display("FAIL draw_b: got v=%0d fb=%0b cyc=%0d, want v=%0d fb=%0b cyc=%0d",
                        value_b, fb_b, cyc, e.val, e.fb, e.cyc);
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drain(string name);
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 30) begin
         step();
         n++;
      end
      tests++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: pending a=%0d b=%0d, want 0 0",
                  name, q_a.size(), q_b.size());
         q_a.delete();
         q_b.delete();
      end
   endtask

   task automatic draw_a(vec_t v);
      exp_t e;
      seed_load_a = 1'b1;
      seed_in_a   = v.seed;
      step();
      seed_load_a = 1'b0;
      req_a       = 1'b1;
      limit_a     = v.lim;
      e.val = v.val;
      e.fb  = v.fb;
      e.cyc = cyc + 1 + v.edges;
      q_a.push_back(e);
      step();
      req_a = 1'b0;
      drain("draw_a");
      step();
   endtask

   vec_t vecs[7];

   initial begin
      int first_ret;
      bit saw_zero;
      exp_t e;

      vecs[0] = '{16'h0001, 2'd3, 2'd1, 1'b0, 1};
      vecs[1] = '{16'h0003, 2'd3, 2'd2, 1'b0, 2};
      vecs[2] = '{16'hACE1, 2'd0, 2'd1, 1'b0, 1};
      vecs[3] = '{16'h0002, 2'd2, 2'd0, 1'b0, 2};
      vecs[4] = '{16'h0003, 2'd1, 2'd0, 1'b0, 3};
      vecs[5] = '{16'h8000, 2'd1, 2'd0, 1'b0, 1};
      vecs[6] = '{16'h0007, 2'd3, 2'd2, 1'b0, 2};

      reset = 1'b1;
      en_a = 0; seed_load_a = 0; req_a = 0; seed_in_a = 0; limit_a = 0;
      en_b = 0; seed_load_b = 0; req_b = 0; seed_in_b = 0; limit_b = 0;
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_state", state_a, 16'h0001);
      check("rst_busy", busy_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_value", value_a, 0);
      check("rst_fallback", fb_a, 0);

      // known sequence from SEED
      step();
      en_a = 1'b1;
      repeat (11) step();
      check("step11", state_a, 16'h0801);
      repeat (2) step();
      check("step13", state_a, 16'h2005);
      check("step13_bit", bit_a, 1);
      en_a = 1'b0;

      // full period
      do_reset();
      en_a = 1'b1;
      first_ret = -1;
      saw_zero = 1'b0;
      for (int i = 1; i <= 65535; i++) begin
         step();
         if (state_a == 16'h0) saw_zero = 1'b1;
         if (state_a == 16'h0001 && first_ret < 0) first_ret = i;
      end
      en_a = 1'b0;
      check("period", first_ret, 65535);
      check("never_zero", saw_zero, 0);

      // seed loading
      seed_load_a = 1'b1;
      seed_in_a   = 16'h0;
      step();
      check("seed_zero", state_a, 16'h0001);
      seed_in_a = 16'hACE1;
      en_a      = 1'b1;
      step();
      check("seed_over_step", state_a, 16'hACE1);
      seed_load_a = 1'b0;
      en_a        = 1'b0;

      // first-draw busy timing after reset
      do_reset();
      req_a   = 1'b1;
      limit_a = 2'd3;
      e = '{2'd1, 1'b0, cyc + 2};
      q_a.push_back(e);
      step();
      req_a = 1'b0;
      @(negedge clk);
      check("busy_draw", busy_a, 1);
      step();
      @(negedge clk);
      check("busy_done", busy_a, 0);
      drain("first");

      // table
      for (int i = 0; i < 7; i++) draw_a(vecs[i]);

      // fallback on b
      seed_load_b = 1'b1;
      seed_in_b   = 16'h0003;
      step();
      seed_load_b = 1'b0;
      req_b       = 1'b1;
      limit_b     = 2'd1;
      e = '{2'd0, 1'b1, cyc + 3};
      q_b.push_back(e);
      step();
      req_b = 1'b0;
      drain("fallback");
      check("fb_hold", fb_b, 1);

      // reset mid-draw
      seed_load_a = 1'b1;
      seed_in_a   = 16'h0003;
      step();
      seed_load_a = 1'b0;
      req_a       = 1'b1;
      limit_a     = 2'd1;
      step();
      req_a = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", busy_a, 0);
      check("abort_state", state_a, 16'h0001);
      check("abort_value", value_a, 0);
      repeat (6) step();

      // req held through the draw
      seed_load_a = 1'b1;
      seed_in_a   = 16'h0003;
      step();
      seed_load_a = 1'b0;
      req_a       = 1'b1;
      limit_a     = 2'd3;
      e = '{2'd2, 1'b0, cyc + 3};
      q_a.push_back(e);
      repeat (3) step();
      req_a = 1'b0;
      drain("held");
      repeat (4) step();
      check("held_hold_value", value_a, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Fibonacci LFSR random source with configurable width, tap mask and seed.
- Adds seed reload with all-zero lockup protection and a registered request/valid draw port that returns a uniform value below a caller-supplied limit, using bounded rejection sampling.
- Serves ghost AI direction choice and other game-logic randomness; one instance per consumer, each with its own SEED.

Parameters:
- WIDTH, 16, LFSR state width (>= 3).
- TAPS, 16'hB400, tap mask with bit i set meaning state bit i feeds the XOR. Default is x^16+x^14+x^13+x^11+1 (bits 15,13,12,10).
- SEED, 16'h0001, reset and lockup-recovery state. Must be nonzero.
- OUT_BITS, 2, draw value width (1..WIDTH).
- MAX_TRIES, 8, rejections allowed before the fallback result (>= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance LFSR one step per cycle while in IDLE.
- seed_load  in  1  load seed_in into the state this cycle.
- seed_in  in  WIDTH  seed value.
- req  in  1  draw request, sampled only in IDLE.
- limit  in  OUT_BITS  exclusive upper bound for the draw; 0 means full range.
- state_out  out  WIDTH  current LFSR state.
- bit_out  out  1  equals state_out[0], the most recently inserted feedback bit.
- busy  out  1  high in DRAW.
- valid  out  1  one-cycle pulse when value is updated.
- value  out  OUT_BITS  draw result, held until the next valid.
- fallback  out  1  qualifies valid: the result came from the retry limit, not an accepted candidate.

Behaviour:
- Reset values: state = SEED, FSM = IDLE, busy = 0, valid = 0, value = 0, fallback = 0, try counter = 0.
- Step: fb = XOR-reduce(state & TAPS); state <= {state[WIDTH-2:0], fb}.
- State update priority (highest first): reset, then seed_load, then step.
  - Step occurs in IDLE when en = 1, and in DRAW every cycle regardless of en.
- seed_load: state <= seed_in. If seed_in == 0, state <= SEED instead, so the lockup state is never entered. A load during DRAW is allowed; the draw continues from the loaded state next cycle, and no step occurs that cycle.
- FSM states: IDLE and DRAW.
- IDLE -> DRAW when req = 1. On that edge:
  - latch limit into limit_q;
  - clear the try counter.
  - The LFSR follows en/seed_load as usual on this edge.
- DRAW cycle processing:
  - candidate = state[OUT_BITS-1:0] of the current cycle.
  - Accept when limit_q == 0, or when candidate < limit_q (unsigned).
  - On accept: value <= candidate, fallback <= 0, valid <= 1 next cycle, return to IDLE.
  - On reject: try counter increments and the state steps.
  - If this rejection brings the counter to MAX_TRIES: value <= 0, fallback <= 1, valid <= 1, return to IDLE.
- Latency: req sampled at edge N, DRAW during cycle N+1, valid high in cycle N+2 when the first candidate is accepted. Each rejection adds one cycle. Worst case is MAX_TRIES+1 cycles from req to valid.
- req while busy is ignored. Requests are not queued.
- req in the same cycle valid is high is accepted normally (the FSM is already in IDLE).
- valid is high for exactly one cycle per accepted request.
- value and fallback hold between draws.
- Reset mid-draw: aborts the draw; outputs return to reset values and no valid is issued.
- state_out and bit_out are direct register outputs with no extra latency.

Test Plan:
- Defaults, reset, then en = 1 for 11 cycles -> state_out = 16'h0801. After 13 cycles -> 16'h2005, with bit_out = 1.
- Free-run en = 1 for 65535 cycles after reset -> state_out returns to 16'h0001, and never equals 0 in between.
- seed_load = 1 with seed_in = 0 -> next state_out = 16'h0001. Then seed_in = 16'hACE1 together with en = 1 -> 16'hACE1 (load wins over step).
- After reset, req = 1 with limit = 3 -> busy high 1 cycle, valid in cycle N+2, value = 1, fallback = 0.
- seed_load 16'h0003, then req with limit = 3 -> candidate 3 rejected, state steps to 16'h0006, candidate 2 accepted -> value = 2, valid at N+3.
- MAX_TRIES = 2, seed 16'h0003, limit = 1 -> candidates 3 and 2 rejected -> value = 0, fallback = 1, valid at N+3.
- Reset asserted during DRAW -> busy = 0 next cycle and no valid pulse.
- req held during busy -> exactly one valid per accepted request.
